// File: rtl/pwm_halfbridge_if.sv
// Control/status bundle between the register logic and one half-bridge PWM leg.
// The register side uses the master modport and the PWM core uses the slave modport.
interface pwm_halfbridge_if #(
    parameter int N    = 8,
    parameter int DT_W = 4,
    parameter int PS_W = 8
);
    logic            ena;
    logic [N-1:0]    period;
    logic [N-1:0]    duty;
    logic [DT_W-1:0] dead_time;
    logic [PS_W-1:0] prescale;
    logic            fault;
    logic            fault_clr;
    logic            out_hi;
    logic            out_lo;
    logic            period_start;
    logic            faulted;

    modport master (
        output ena,
        output period,
        output duty,
        output dead_time,
        output prescale,
        output fault,
        output fault_clr,
        input  out_hi,
        input  out_lo,
        input  period_start,
        input  faulted
    );

    modport slave (
        input  ena,
        input  period,
        input  duty,
        input  dead_time,
        input  prescale,
        input  fault,
        input  fault_clr,
        output out_hi,
        output out_lo,
        output period_start,
        output faulted
    );
endinterface

// File: rtl/pwm_halfbridge.sv
// Complementary high/low gate-drive PWM for one half-bridge leg with shadowed period/duty,
// prescaler and dead-time insertion. Define PWM_FAULT_EN to build the synchronized fault latch.
module pwm_halfbridge #(
    parameter int N    = 8,
    parameter int DT_W = 4,
    parameter int PS_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    pwm_halfbridge_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DT_TO_HI = 3'd1,
        ST_HI_ON    = 3'd2,
        ST_DT_TO_LO = 3'd3,
        ST_LO_ON    = 3'd4
    } state_t;

    localparam logic [N-1:0]    CNT_ZERO = {N{1'b0}};
    localparam logic [N-1:0]    CNT_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [PS_W-1:0] PS_ZERO  = {PS_W{1'b0}};
    localparam logic [PS_W-1:0] PS_ONE   = {{(PS_W-1){1'b0}}, 1'b1};
    localparam logic [DT_W-1:0] DT_ZERO  = {DT_W{1'b0}};
    localparam logic [DT_W-1:0] DT_ONE   = {{(DT_W-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;
    logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;
    logic [N-1:0]    cnt_q, cnt_d;
    logic [N-1:0]    p_sh_q, p_sh_d;
    logic [N-1:0]    d_sh_q, d_sh_d;
    logic            run_q, run_d;
    logic            period_start_q, period_start_d;
    logic            out_hi_q, out_hi_d;
    logic            out_lo_q, out_lo_d;

    logic            halt_s;
    logic            tick_s;
    logic            wrap_s;
    logic            raw_s;
    logic            faulted_s;

`ifdef PWM_FAULT_EN
    logic fault_meta_q, fault_sync_q;
    logic faulted_q, faulted_d;

    // A synchronized fault always wins; the latch only clears once the fault is gone.
    always_comb begin
        faulted_d = faulted_q;
        if (fault_sync_q) begin
            faulted_d = 1'b1;
        end else if (bus.fault_clr) begin
            faulted_d = 1'b0;
        end else begin
            faulted_d = faulted_q;
        end
    end

    // Two-flop synchronizer for the asynchronous fault pin plus the fault latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_meta_q <= 1'b0;
            fault_sync_q <= 1'b0;
            faulted_q    <= 1'b0;
        end else begin
            fault_meta_q <= bus.fault;
            fault_sync_q <= fault_meta_q;
            faulted_q    <= faulted_d;
        end
    end

    assign halt_s    = ~bus.ena | fault_sync_q | faulted_q;
    assign faulted_s = faulted_q;
`else
    logic unused_fault_inputs_s;

    assign unused_fault_inputs_s = bus.fault ^ bus.fault_clr;
    assign halt_s                = ~bus.ena;
    assign faulted_s             = 1'b0;
`endif

    // Greater-or-equal keeps the prescaler from running away if prescale is lowered mid-count.
    assign tick_s = (ps_cnt_q >= bus.prescale);
    assign wrap_s = tick_s & (cnt_q == p_sh_q);
    assign raw_s  = (cnt_q < d_sh_q);

    // Prescaler, period counter and shadow registers; a restart reloads shadows from cnt=0.
    always_comb begin
        ps_cnt_d       = ps_cnt_q;
        cnt_d          = cnt_q;
        p_sh_d         = p_sh_q;
        d_sh_d         = d_sh_q;
        period_start_d = 1'b0;
        run_d          = ~halt_s;
        if (halt_s) begin
            ps_cnt_d = PS_ZERO;
            cnt_d    = CNT_ZERO;
        end else if (!run_q) begin
            ps_cnt_d = PS_ZERO;
            cnt_d    = CNT_ZERO;
            p_sh_d   = bus.period;
            d_sh_d   = bus.duty;
        end else if (tick_s) begin
            ps_cnt_d = PS_ZERO;
            if (wrap_s) begin
                cnt_d          = CNT_ZERO;
                p_sh_d         = bus.period;
                d_sh_d         = bus.duty;
                period_start_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            ps_cnt_d = ps_cnt_q + PS_ONE;
        end
    end

    // Dead-time FSM: every change of side passes through a both-off interval.
    always_comb begin
        state_d  = state_q;
        dt_cnt_d = dt_cnt_q;
        if (halt_s || !run_q) begin
            state_d  = ST_IDLE;
            dt_cnt_d = DT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dt_cnt_d = DT_ZERO;
                    if (raw_s) begin
                        state_d = ST_DT_TO_HI;
                    end else begin
                        state_d = ST_DT_TO_LO;
                    end
                end
                ST_DT_TO_HI: begin
                    if (!raw_s) begin
                        state_d  = ST_DT_TO_LO;
                        dt_cnt_d = DT_ZERO;
                    end else if (dt_cnt_q >= bus.dead_time) begin
                        state_d  = ST_HI_ON;
                        dt_cnt_d = DT_ZERO;
                    end else begin
                        state_d  = ST_DT_TO_HI;
                        dt_cnt_d = dt_cnt_q + DT_ONE;
                    end
                end
                ST_HI_ON: begin
                    if (!raw_s) begin
                        state_d  = ST_DT_TO_LO;
                        dt_cnt_d = DT_ZERO;
                    end else begin
                        state_d = ST_HI_ON;
                    end
                end
                ST_DT_TO_LO: begin
                    if (raw_s) begin
                        state_d  = ST_DT_TO_HI;
                        dt_cnt_d = DT_ZERO;
                    end else if (dt_cnt_q >= bus.dead_time) begin
                        state_d  = ST_LO_ON;
                        dt_cnt_d = DT_ZERO;
                    end else begin
                        state_d  = ST_DT_TO_LO;
                        dt_cnt_d = dt_cnt_q + DT_ONE;
                    end
                end
                ST_LO_ON: begin
                    if (raw_s) begin
                        state_d  = ST_DT_TO_HI;
                        dt_cnt_d = DT_ZERO;
                    end else begin
                        state_d = ST_LO_ON;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    dt_cnt_d = DT_ZERO;
                end
            endcase
        end
        out_hi_d = (state_d == ST_HI_ON);
        out_lo_d = (state_d == ST_LO_ON);
    end

    // State registers; reset forces both gate commands off immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            dt_cnt_q       <= DT_ZERO;
            ps_cnt_q       <= PS_ZERO;
            cnt_q          <= CNT_ZERO;
            p_sh_q         <= CNT_ZERO;
            d_sh_q         <= CNT_ZERO;
            run_q          <= 1'b0;
            period_start_q <= 1'b0;
            out_hi_q       <= 1'b0;
            out_lo_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            dt_cnt_q       <= dt_cnt_d;
            ps_cnt_q       <= ps_cnt_d;
            cnt_q          <= cnt_d;
            p_sh_q         <= p_sh_d;
            d_sh_q         <= d_sh_d;
            run_q          <= run_d;
            period_start_q <= period_start_d;
            out_hi_q       <= out_hi_d;
            out_lo_q       <= out_lo_d;
        end
    end

    assign bus.out_hi       = out_hi_q;
    assign bus.out_lo       = out_lo_q;
    assign bus.period_start = period_start_q;
    assign bus.faulted      = faulted_s;

endmodule

// File: tb/tb_pwm_halfbridge.sv
// Bench for pwm_halfbridge: per-period count vectors, hand-written corner sequences and
// randomized stimulus against a dead-time window model of the gate outputs.
module tb_pwm_halfbridge;

    logic clk;
    logic rst;

    pwm_halfbridge_if #(.N(8), .DT_W(4), .PS_W(8)) bus ();

    pwm_halfbridge #(.N(8), .DT_W(4), .PS_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: counter arithmetic plus a history of the raw demand
    // (1/0 while running, 2 while stopped).
    int m_cnt, m_ps, m_psh, m_dsh;
    bit m_run;
    int hist[$];
    bit model_on;
    bit m_exp_hi, m_exp_lo, m_exp_ps;

    typedef struct {
        int period;
        int duty;
        int ps;
        int dt;
        int len;
        int exp_hi;
        int exp_lo;
        int exp_ps;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_ps = 0; m_psh = 0; m_dsh = 0; m_run = 0;
        hist.delete();
    endtask

    // An output is on only after the raw demand has held its level for dead_time+2 samples.
    task automatic model_edge();
        bit halt;
        bit all1, all0;
        int n;
        halt = !bus.ena;
        n = int'(bus.dead_time) + 2;
        all1 = 0; all0 = 0;
        if (!halt && hist.size() >= n) begin
            all1 = 1; all0 = 1;
            for (int i = hist.size() - n; i < hist.size(); i++) begin
                if (hist[i] != 1) all1 = 0;
                if (hist[i] != 0) all0 = 0;
            end
        end
        m_exp_hi = all1;
        m_exp_lo = all0;
        m_exp_ps = 0;
        if (halt) begin
            m_cnt = 0; m_ps = 0; m_run = 0;
        end else if (!m_run) begin
            m_psh = int'(bus.period); m_dsh = int'(bus.duty);
            m_cnt = 0; m_ps = 0; m_run = 1;
        end else if (m_ps == int'(bus.prescale)) begin
            m_ps = 0;
            if (m_cnt == m_psh) begin
                m_cnt = 0;
                m_psh = int'(bus.period); m_dsh = int'(bus.duty);
                m_exp_ps = 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else begin
            m_ps = m_ps + 1;
        end
        if (halt) hist.push_back(2);
        else hist.push_back((m_cnt < m_dsh) ? 1 : 0);
        if (hist.size() > 24) void'(hist.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (model_on) begin
            chk("out_hi", bus.out_hi, m_exp_hi);
            chk("out_lo", bus.out_lo, m_exp_lo);
            chk("period_start", bus.period_start, m_exp_ps);
            chk("faulted", bus.faulted, 0);
        end
        chk("no_overlap", bus.out_hi & bus.out_lo, 0);
    endtask

    task automatic configure(input int p, input int d, input int ps, input int dt);
        bus.ena       = 1'b0;
        bus.period    = 8'(p);
        bus.duty      = 8'(d);
        bus.prescale  = 8'(ps);
        bus.dead_time = 4'(dt);
        step();
        bus.ena = 1'b1;
    endtask

    task automatic wait_hi(input string name);
        bit ok;
        ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            step();
            if (bus.out_hi) ok = 1;
        end
        chk(name, ok, 1);
    endtask

    initial begin
        int hi, lo, pss;
        bit ok;

        vecs[0] = '{9, 4, 0, 2, 10, 1, 3, 1};
        vecs[1] = '{9, 0, 0, 2, 10, 0, 10, 1};
        vecs[2] = '{9, 255, 0, 2, 10, 10, 0, 1};
        vecs[3] = '{4, 2, 3, 0, 20, 7, 11, 1};
        vecs[4] = '{9, 4, 0, 0, 10, 3, 5, 1};
        vecs[5] = '{0, 1, 0, 1, 8, 8, 0, 8};
        vecs[6] = '{0, 0, 2, 3, 9, 0, 9, 3};
        vecs[7] = '{7, 3, 1, 1, 16, 4, 8, 1};

        rst = 1'b0;
        model_on = 1'b1;
        bus.ena = 1'b1; bus.period = 8'd9; bus.duty = 8'd4;
        bus.prescale = 8'd0; bus.dead_time = 4'd2;
        bus.fault = 1'b0; bus.fault_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_hi", bus.out_hi, 0);
        chk("rst_out_lo", bus.out_lo, 0);
        chk("rst_period_start", bus.period_start, 0);
        chk("rst_faulted", bus.faulted, 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // Steady-state on/off/wrap counts over one full period.
        for (int v = 0; v < 8; v++) begin
            configure(vecs[v].period, vecs[v].duty, vecs[v].ps, vecs[v].dt);
            repeat (3 * vecs[v].len + 20) step();
            hi = 0; lo = 0; pss = 0;
            repeat (vecs[v].len) begin
                step();
                hi += int'(bus.out_hi);
                lo += int'(bus.out_lo);
                pss += int'(bus.period_start);
            end
            chk($sformatf("vec%0d_hi_count", v), hi, vecs[v].exp_hi);
            chk($sformatf("vec%0d_lo_count", v), lo, vecs[v].exp_lo);
            chk($sformatf("vec%0d_ps_count", v), pss, vecs[v].exp_ps);
        end

        // Duty change at cnt=2 only takes effect after the next wrap.
        configure(9, 4, 0, 0);
        repeat (30) step();
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            step();
            if (bus.period_start) ok = 1;
        end
        chk("ps_wait", ok, 1);
        hi = int'(bus.out_hi);
        repeat (2) begin step(); hi += int'(bus.out_hi); end
        bus.duty = 8'd7;
        repeat (7) begin step(); hi += int'(bus.out_hi); end
        chk("shadow_old_duty_hi", hi, 3);
        step();
        chk("shadow_wrap_ps", bus.period_start, 1);
        hi = int'(bus.out_hi);
        repeat (9) begin step(); hi += int'(bus.out_hi); end
        chk("shadow_new_duty_hi", hi, 6);

        // Asynchronous reset while the high side is on, then restart latency.
        configure(9, 4, 0, 2);
        wait_hi("wait_hi_before_rst");
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_hi", bus.out_hi, 0);
        chk("async_rst_lo", bus.out_lo, 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (4) begin
            step();
            chk("restart_hi_off", bus.out_hi, 0);
            chk("restart_lo_off", bus.out_lo, 0);
        end
        step();
        chk("restart_hi_on", bus.out_hi, 1);

`ifdef PWM_FAULT_EN
        // One-clock fault during HI_ON, priority over fault_clr, then clear and restart.
        model_on = 1'b0;
        bus.fault = 1'b1;
        step();
        bus.fault = 1'b0;
        repeat (2) step();
        chk("fault_hi_off", bus.out_hi, 0);
        chk("fault_lo_off", bus.out_lo, 0);
        chk("fault_latched", bus.faulted, 1);
        repeat (5) step();
        chk("fault_held", bus.faulted, 1);
        chk("fault_held_hi", bus.out_hi, 0);
        bus.fault = 1'b1;
        bus.fault_clr = 1'b1;
        repeat (4) step();
        chk("fault_priority", bus.faulted, 1);
        bus.fault = 1'b0;
        bus.fault_clr = 1'b0;
        repeat (3) step();
        chk("fault_still_latched", bus.faulted, 1);
        bus.fault_clr = 1'b1;
        step();
        bus.fault_clr = 1'b0;
        chk("fault_cleared", bus.faulted, 0);
        repeat (4) begin
            step();
            chk("fault_restart_hi_off", bus.out_hi, 0);
            chk("fault_restart_lo_off", bus.out_lo, 0);
        end
        step();
        chk("fault_restart_hi_on", bus.out_hi, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        model_on = 1'b1;
`endif

        // Randomized segments; dead time and prescale only change while disabled.
        for (int seg = 0; seg < 60; seg++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.ena = 1'b0;
                bus.dead_time = 4'($urandom_range(0, 5));
                bus.prescale = 8'($urandom_range(0, 3));
                repeat ($urandom_range(1, 3)) step();
            end
            bus.ena = 1'b1;
            bus.period = 8'($urandom_range(0, 12));
            bus.duty = 8'($urandom_range(0, 14));
            repeat ($urandom_range(10, 60)) begin
                step();
                if ($urandom_range(0, 7) == 0) bus.duty = 8'($urandom_range(0, 14));
                if ($urandom_range(0, 15) == 0) bus.period = 8'($urandom_range(0, 12));
`ifndef PWM_FAULT_EN
                bus.fault = 1'($urandom_range(0, 1));
                bus.fault_clr = 1'($urandom_range(0, 1));
`endif
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
